// File: rtl/rsa_loader_pkg.sv
// rsa_loader_pkg: shared constants for the RSA command loader.
package rsa_loader_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CSUM    = 2'd3;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_LD_MSG = 8'h01;
    localparam logic [7:0] CMD_LD_EXP = 8'h02;
    localparam logic [7:0] CMD_LD_MOD = 8'h03;
    localparam logic [7:0] CMD_START  = 8'h10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD   = 2'd1;
    localparam logic [1:0] ERR_BAD_CSUM  = 2'd2;
    localparam logic [1:0] ERR_NOT_READY = 2'd3;
    function automatic logic is_load(input logic [7:0] c);
        return c == CMD_LD_MSG || c == CMD_LD_EXP || c == CMD_LD_MOD;
    endfunction
endpackage

// File: rtl/rsa_cmd_loader_if.sv
// rsa_cmd_loader_if: byte stream in, operands and control pulses out.
interface rsa_cmd_loader_if #(parameter int WIDTH = 32);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             core_busy;
    logic [WIDTH-1:0] msg;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] mod;
    logic [2:0]       loaded;
    logic             start;
    logic             err;
    logic [1:0]       err_code;
    modport master(output rx_data, rx_valid, core_busy,
                   input msg, exp, mod, loaded, start, err, err_code);
    modport slave(input rx_data, rx_valid, core_busy,
                  output msg, exp, mod, loaded, start, err, err_code);
endinterface

// File: rtl/rsa_loader_timeout.sv
// rsa_loader_timeout: inter-byte watchdog, pulses expired after TIMEOUT_CYCLES idle cycles.
module rsa_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] r_cnt;
    // a byte in the expiry cycle takes priority over the timeout
    assign expired = run && !kick && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (!run || kick || expired) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/rsa_cmd_loader.sv
// rsa_cmd_loader: parses framed host commands (A5, CMD, payload, XOR csum) into
// RSA operands and a start pulse; reports bad command, bad checksum, not ready, timeout.
module rsa_cmd_loader
    import rsa_loader_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic              clk,
    input logic              rst_n,
    rsa_cmd_loader_if.slave  bus
);
    localparam int NB = WIDTH / 8;
    localparam int BW = $clog2(NB + 1);
    logic [1:0]       r_state;
    logic [7:0]       r_cmd;
    logic [BW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_shift;
    logic [7:0]       r_xor;
    logic [WIDTH-1:0] r_msg, r_exp, r_mod;
    logic [2:0]       r_loaded;
    logic             r_start, r_err;
    logic [1:0]       r_code;
    logic             w_expired;
    logic [7:0]       w_byte;
    logic             w_valid, w_busy;
    assign w_byte  = bus.rx_data;
    assign w_valid = bus.rx_valid;
    assign w_busy  = bus.core_busy;
    rsa_loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk), .rst_n(rst_n), .run(r_state != ST_IDLE), .kick(w_valid), .expired(w_expired)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_xor    <= '0;
            r_msg    <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_loaded <= '0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= '0;
        end else begin
            r_start <= 1'b0;
            r_err   <= 1'b0;
            if (w_expired) begin
                r_state <= ST_IDLE;
                r_err   <= 1'b1;
                r_code  <= ERR_TIMEOUT;
            end else if (w_valid) begin
                case (r_state)
                    ST_IDLE: if (w_byte == SYNC_BYTE) r_state <= ST_CMD;
                    ST_CMD: begin
                        r_cmd  <= w_byte;
                        r_xor  <= w_byte;
                        r_bcnt <= '0;
                        r_shift <= '0;
                        if (is_load(w_byte)) r_state <= ST_PAYLOAD;
                        else if (w_byte == CMD_START) r_state <= ST_CSUM;
                        else begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                            r_code  <= ERR_BAD_CMD;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_shift <= (r_shift << 8) | WIDTH'(w_byte);
                        r_xor   <= r_xor ^ w_byte;
                        r_bcnt  <= r_bcnt + 1'b1;
                        if (r_bcnt == BW'(NB - 1)) r_state <= ST_CSUM;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        if (w_byte != r_xor) begin
                            r_err  <= 1'b1;
                            r_code <= ERR_BAD_CSUM;
                        end else if (r_cmd == CMD_START ? (w_busy || r_loaded != 3'b111) : w_busy) begin
                            r_err  <= 1'b1;
                            r_code <= ERR_NOT_READY;
                        end else if (r_cmd == CMD_START) r_start <= 1'b1;
                        else begin
                            if (r_cmd == CMD_LD_MSG) r_msg <= r_shift;
                            if (r_cmd == CMD_LD_EXP) r_exp <= r_shift;
                            if (r_cmd == CMD_LD_MOD) r_mod <= r_shift;
                            r_loaded <= r_loaded | (3'b001 << (r_cmd[1:0] - 2'd1));
                        end
                    end
                endcase
            end
        end
    end
    assign bus.msg      = r_msg;
    assign bus.exp      = r_exp;
    assign bus.mod      = r_mod;
    assign bus.loaded   = r_loaded;
    assign bus.start    = r_start;
    assign bus.err      = r_err;
    assign bus.err_code = r_code;
endmodule

// File: tb/tb_rsa_cmd_loader.sv
// tb_rsa_cmd_loader: scenario tasks plus a pulse scoreboard for rsa_cmd_loader (WIDTH=32).
module tb_rsa_cmd_loader;
    localparam int W  = 32;
    localparam int TO = 20;
    typedef struct packed {logic is_start; logic [1:0] code;} ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    ev_t q[$];
    ev_t e;
    rsa_cmd_loader_if #(.WIDTH(W)) bus();
    rsa_cmd_loader #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // every start/err pulse must match the oldest expected event
    always @(posedge clk) begin
        #1;
        if (rst_n && (bus.start || bus.err)) begin
            total++;
            if (bus.start && bus.err) begin
                bad++;
                $display("FAIL pulse_overlap got start=1 err=1 want only one");
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got start=%0d err=%0d code=%0d want none", bus.start, bus.err, bus.err_code);
            end else begin
                e = q.pop_front();
                if (e.is_start ? !bus.start : (!bus.err || bus.err_code !== e.code)) begin
                    bad++;
                    $display("FAIL pulse got start=%0d err=%0d code=%0d want start=%0d code=%0d",
                             bus.start, bus.err, bus.err_code, e.is_start, e.code);
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end
    function automatic logic [7:0] cs_of(input logic [7:0] c, input logic [31:0] v);
        return c ^ v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
    endfunction
    function automatic ev_t err_ev(input logic [1:0] c);
        return '{is_start: 1'b0, code: c};
    endfunction
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask
    task automatic send_load(input logic [7:0] c, input logic [31:0] v, input logic [7:0] cs, input bit ex, input ev_t ev);
        send_byte(8'hA5);
        send_byte(c);
        for (int i = 3; i >= 0; i--) send_byte(v[i*8+:8]);
        if (ex) q.push_back(ev);
        send_byte(cs);
    endtask
    task automatic send_start(input bit ex, input ev_t ev);
        send_byte(8'hA5);
        send_byte(8'h10);
        if (ex) q.push_back(ev);
        send_byte(8'h10);
    endtask
    task automatic check_drained(input string n);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_pulse got pending=%0d want 0", n, q.size());
            q.delete();
        end
    endtask
    task automatic test_reset;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.core_busy = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.msg, bus.exp, bus.mod, bus.loaded, bus.start, bus.err, bus.err_code} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got msg=%h exp=%h mod=%h loaded=%b start=%b err=%b code=%0d want all 0",
                     bus.msg, bus.exp, bus.mod, bus.loaded, bus.start, bus.err, bus.err_code);
        end
    endtask
    task automatic test_load;
        send_load(8'h01, 32'h12345678, 8'h09, 0, err_ev(0));
        total++;
        if (bus.msg !== 32'h12345678 || bus.loaded !== 3'b001) begin
            bad++;
            $display("FAIL load_msg got msg=%h loaded=%b want 12345678 001", bus.msg, bus.loaded);
        end
        send_load(8'h01, 32'hAABBCCDD, 8'h0A, 1, err_ev(2));
        total++;
        if (bus.msg !== 32'h12345678 || bus.err_code !== 2'd2) begin
            bad++;
            $display("FAIL bad_csum got msg=%h code=%0d want 12345678 2", bus.msg, bus.err_code);
        end
        check_drained("load");
    endtask
    task automatic test_start_gating;
        send_start(1, err_ev(3));
        send_load(8'h02, 32'h00010001, cs_of(8'h02, 32'h00010001), 0, err_ev(0));
        send_load(8'h03, 32'hC0FFEE01, cs_of(8'h03, 32'hC0FFEE01), 0, err_ev(0));
        total++;
        if (bus.exp !== 32'h00010001 || bus.mod !== 32'hC0FFEE01 || bus.loaded !== 3'b111) begin
            bad++;
            $display("FAIL load_exp_mod got exp=%h mod=%h loaded=%b want 00010001 c0ffee01 111", bus.exp, bus.mod, bus.loaded);
        end
        send_start(1, '{is_start: 1'b1, code: 2'd0});
        total++;
        if (bus.start !== 1'b1) begin
            bad++;
            $display("FAIL start_latency got start=%b want 1", bus.start);
        end
        @(negedge clk);
        total++;
        if (bus.start !== 1'b0) begin
            bad++;
            $display("FAIL start_width got start=%b want 0", bus.start);
        end
        check_drained("start");
    endtask
    task automatic test_busy;
        bus.core_busy = 1'b1;
        send_load(8'h03, 32'h11223344, cs_of(8'h03, 32'h11223344), 1, err_ev(3));
        total++;
        if (bus.mod !== 32'hC0FFEE01 || bus.err_code !== 2'd3) begin
            bad++;
            $display("FAIL busy_load got mod=%h code=%0d want c0ffee01 3", bus.mod, bus.err_code);
        end
        send_start(1, err_ev(3));
        bus.core_busy = 1'b0;
        check_drained("busy");
    endtask
    task automatic test_timeout;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TO - 1) @(negedge clk);
        q.push_back(err_ev(0));
        @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.err_code !== 2'd0) begin
            bad++;
            $display("FAIL timeout got err=%b code=%0d want 1 0", bus.err, bus.err_code);
        end
        send_load(8'h01, 32'hDEADBEEF, cs_of(8'h01, 32'hDEADBEEF), 0, err_ev(0));
        total++;
        if (bus.msg !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL after_timeout got msg=%h want deadbeef", bus.msg);
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h09);
        total++;
        if (bus.msg !== 32'h12345678 || bus.err_code !== 2'd0) begin
            bad++;
            $display("FAIL expiry_byte_wins got msg=%h code=%0d want 12345678 0", bus.msg, bus.err_code);
        end
        check_drained("timeout");
    endtask
    task automatic test_framing;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_byte(8'hA5);
        q.push_back(err_ev(1));
        send_byte(8'h07);
        total++;
        if (bus.err_code !== 2'd1) begin
            bad++;
            $display("FAIL bad_cmd got code=%0d want 1", bus.err_code);
        end
        send_byte(8'hA5);
        q.push_back(err_ev(1));
        send_byte(8'hA5);
        send_start(1, '{is_start: 1'b1, code: 2'd0});
        total++;
        if (bus.loaded !== 3'b111 || bus.msg !== 32'h12345678) begin
            bad++;
            $display("FAIL framing_regs got loaded=%b msg=%h want 111 12345678", bus.loaded, bus.msg);
        end
        check_drained("framing");
    endtask
    task automatic test_reset_mid;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.msg, bus.exp, bus.mod, bus.loaded, bus.start, bus.err, bus.err_code} !== '0) begin
            bad++;
            $display("FAIL reset_mid got msg=%h exp=%h mod=%h loaded=%b code=%0d want all 0",
                     bus.msg, bus.exp, bus.mod, bus.loaded, bus.err_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_load(8'h02, 32'h00010001, 8'h02, 0, err_ev(0));
        total++;
        if (bus.exp !== 32'h00010001 || bus.loaded !== 3'b010 || bus.msg !== 32'h0) begin
            bad++;
            $display("FAIL reload_exp got exp=%h loaded=%b msg=%h want 00010001 010 0", bus.exp, bus.loaded, bus.msg);
        end
        check_drained("reset_mid");
    endtask
    initial begin
        test_reset;
        test_load;
        test_start_gating;
        test_busy;
        test_timeout;
        test_framing;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rsa_cmd_loader.md
Name: rsa_cmd_loader

Overview:
- Sits between the UART byte receiver and the RSA core.
- Parses framed host commands from the received byte stream and assembles multi-byte operands (message, exponent, modulus).
- Validates each frame with an XOR checksum, then commits the operand or issues a single-cycle start pulse to the core.
- Aborts on malformed frames and on inter-byte timeouts, and reports the cause.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of 8, range 8..2048.
- TIMEOUT_CYCLES, 100000: maximum idle cycles between bytes inside a frame (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- core_busy  in  1  RSA core is computing.
- msg  out  WIDTH  message operand register.
- exp  out  WIDTH  exponent operand register.
- mod  out  WIDTH  modulus operand register.
- loaded  out  3  sticky flags {mod, exp, msg}.
- start  out  1  one-cycle pulse that launches the core.
- err  out  1  one-cycle error pulse.
- err_code  out  2  cause of the last error; holds its value until the next error.

Behaviour:
- Reset (async assert, sync release): state=IDLE; msg/exp/mod=0; loaded=0; start=0; err=0; err_code=0; timeout counter=0.
- Frame format: SYNC(0xA5), CMD, payload (NB=WIDTH/8 bytes, MSB first, load commands only), CSUM.
  - CSUM = XOR of CMD and all payload bytes.
- Commands:
  - 0x01 load msg; 0x02 load exp; 0x03 load mod (each with NB payload bytes).
  - 0x10 start (no payload).
- FSM states: IDLE, CMD, PAYLOAD, CSUM.
  - IDLE: on a byte equal to 0xA5 -> CMD. Any other byte is silently ignored.
  - CMD:
    - Load command -> PAYLOAD; byte counter=0; shift register cleared; running xor=CMD.
    - Start command -> CSUM.
    - Any other value -> err, code 1 (bad command), then IDLE.
  - PAYLOAD: each byte shifts into {shift[WIDTH-9:0], byte} and is XORed into the running xor. After byte NB-1 -> CSUM.
  - CSUM, mismatch: err, code 2 (bad checksum), then IDLE. No register changes.
  - CSUM, match, load command:
    - If core_busy=1: err, code 3 (not ready); target register is unchanged.
    - Otherwise: target register <= shift register; its loaded bit is set.
    - Then IDLE.
  - CSUM, match, start command:
    - If core_busy=0 and loaded==3'b111: start=1.
    - Otherwise: err, code 3.
    - Then IDLE.
- Latency: the outputs (registers, loaded, start, err, err_code) are updated on the same edge that samples the final rx_valid of the frame, so they are visible in the next cycle.
- start and err are never asserted in the same cycle.
- Timeout:
  - The counter runs while state != IDLE and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 without rx_valid: err, code 0 (timeout), then IDLE. Partial payload is discarded.
  - If rx_valid arrives in the same cycle as expiry, the byte wins: no timeout, and the byte is processed normally.
- Once set, loaded flags stay set (re-run with the same operands is allowed). They clear only on reset.
- Reset mid-frame: immediate return to IDLE; all operand registers and loaded flags are cleared.
- No back-pressure: every rx_valid is consumed in a single cycle.

Decomposition:
- Package rsa_loader_pkg holds:
  - state enum;
  - SYNC_BYTE=8'hA5;
  - CMD_LD_MSG/EXP/MOD, CMD_START;
  - ERR_TIMEOUT=0, ERR_BAD_CMD=1, ERR_BAD_CSUM=2, ERR_NOT_READY=3.
- One sub-module: rsa_loader_timeout. Parameter TIMEOUT_CYCLES; inputs clk, rst_n, run, kick; output expired (one-cycle pulse). Counter width is $clog2(TIMEOUT_CYCLES).

Test Plan (WIDTH=32):
- Load: A5 01 12 34 56 78 09 -> msg=0x12345678, loaded=3'b001, no err. The same frame with CSUM 0x0A -> err pulse, err_code=2, msg unchanged.
- Start gating: A5 10 10 with only msg loaded -> err, code 3. Load exp=0x00010001 and mod=0xC0FFEE01, then A5 10 10 with core_busy=0 -> exactly one start pulse, one cycle after the CSUM strobe.
- Busy rejection: core_busy=1 during a valid mod load -> err code 3, mod unchanged. Same during start -> err code 3, no start pulse.
- Timeout: send A5 01 12, then silence for TIMEOUT_CYCLES -> err code 0, state IDLE. A following full valid frame loads correctly. A byte arriving exactly on the expiry cycle -> no err.
- Framing: noise bytes 00 FF 5A before A5 are ignored. A5 07 -> err code 1. A5 immediately followed by A5 -> the second byte is treated as CMD and gives err code 1.
- Reset: assert rst_n=0 in the middle of the payload -> all outputs zero. After release, A5 02 00 01 00 01 02 -> exp=0x00010001.
